// File: rtl/seq_pkg.sv
// ---------------------------------------------------------------------------
// seq_pkg
// Shared types and width helpers for the child instance sequencer.
//   seq_state_t : sequencer FSM states (IDLE, LAUNCH, WAIT, NEXT, FINISH)
//   IDX_W/CNT_W : index and pass-count widths for the default of 5 children
//   idx_width() : index width for any child count
//   cnt_width() : pass-count width for any child count
// ---------------------------------------------------------------------------
package seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LAUNCH,
        WAIT,
        NEXT,
        FINISH
    } seq_state_t;

    // Index width. It is kept at least 1 bit so that a child count of 1
    // still produces a legal vector.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    // The pass counter must be able to hold the value n itself.
    function automatic int unsigned cnt_width(input int unsigned n);
        return $clog2(n + 1);
    endfunction

    localparam int unsigned DEFAULT_N_INST = 5;
    localparam int unsigned IDX_W          = idx_width(DEFAULT_N_INST);
    localparam int unsigned CNT_W          = cnt_width(DEFAULT_N_INST);

endpackage

// File: rtl/seq_timer.sv
// ---------------------------------------------------------------------------
// seq_timer
// Wait timer used while a child is being serviced.
//   clk     in  : clock, rising edge
//   rst     in  : asynchronous active-high reset
//   clear   in  : reset the count to zero on the next edge
//   enable  in  : count up by one on the next edge
//   expired out : count has reached TIMEOUT-1, which is the last waiting cycle
// ---------------------------------------------------------------------------
module seq_timer #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

    logic [TW-1:0] count;

    // The count starts at 0 in the first waiting cycle. Clear takes
    // priority over enable. Wrap-around past TIMEOUT-1 is harmless: the
    // FSM always leaves WAIT by that point.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + TW'(1);
        end
    end

    assign expired = (count == TW'(TIMEOUT - 1));

endmodule

// File: rtl/child_inst_sequencer.sv
// ---------------------------------------------------------------------------
// child_inst_sequencer
// Starts the N_INST child instances one after another. For each child, it
// waits for that child's done signal or for a timeout. It then records the
// outcome and reports the per-pass status.
//   clk            in  : clock, rising edge
//   rst            in  : asynchronous active-high reset
//   go_i           in  : start a pass (only looked at while idle)
//   abort_i        in  : end the current pass early
//   child_done_i   in  : done from each child (only the selected bit matters)
//   child_start_o  out : one-hot, one-cycle start strobe
//   busy_o         out : pass in progress (LAUNCH through FINISH)
//   done_o         out : one-cycle completion pulse
//   aborted_o      out : last pass was ended by abort_i
//   idx_o          out : index of the child being sequenced
//   timeout_mask_o out : children that timed out in the last pass
//   pass_count_o   out : children that answered done in the last pass
// ---------------------------------------------------------------------------
module child_inst_sequencer
    import seq_pkg::*;
#(
    parameter int unsigned N_INST  = 5,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         go_i,
    input  logic                         abort_i,
    input  logic [N_INST-1:0]            child_done_i,
    output logic [N_INST-1:0]            child_start_o,
    output logic                         busy_o,
    output logic                         done_o,
    output logic                         aborted_o,
    output logic [$clog2(N_INST)-1:0]    idx_o,
    output logic [N_INST-1:0]            timeout_mask_o,
    output logic [$clog2(N_INST+1)-1:0]  pass_count_o
);

    localparam int unsigned IW = idx_width(N_INST);
    localparam int unsigned CW = cnt_width(N_INST);
    localparam logic [IW-1:0] LAST_IDX = IW'(N_INST - 1);

    seq_state_t        state, state_nxt;
    logic [IW-1:0]     idx, idx_nxt;
    logic [N_INST-1:0] mask, mask_nxt;
    logic [CW-1:0]     pass_cnt, pass_cnt_nxt;
    logic              aborted, aborted_nxt;
    logic              timer_clear, timer_en, timer_expired;
    logic              cur_done;

    // Only the selected child's done is relevant. A stray done from any
    // other child cannot advance the sequence.
    assign cur_done = child_done_i[idx];

    seq_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (timer_clear),
        .enable  (timer_en),
        .expired (timer_expired)
    );

    // State and status registers. The status registers (index, mask, count
    // and aborted flag) hold their values after FINISH. They only clear when
    // the next pass is accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            idx      <= '0;
            mask     <= '0;
            pass_cnt <= '0;
            aborted  <= 1'b0;
        end else begin
            state    <= state_nxt;
            idx      <= idx_nxt;
            mask     <= mask_nxt;
            pass_cnt <= pass_cnt_nxt;
            aborted  <= aborted_nxt;
        end
    end

    // Next-state and status updates. In WAIT, the outcome of the current
    // child is recorded before the abort is checked. As a result, a done
    // that arrives in the same cycle as an abort is still counted. A done
    // also beats a timeout in the same cycle because it is tested first.
    always_comb begin
        state_nxt    = state;
        idx_nxt      = idx;
        mask_nxt     = mask;
        pass_cnt_nxt = pass_cnt;
        aborted_nxt  = aborted;
        timer_clear  = 1'b0;
        timer_en     = 1'b0;

        case (state)
            IDLE: begin
                if (go_i) begin
                    idx_nxt      = '0;
                    mask_nxt     = '0;
                    pass_cnt_nxt = '0;
                    aborted_nxt  = 1'b0;
                    state_nxt    = LAUNCH;
                end
            end

            LAUNCH: begin
                timer_clear = 1'b1;
                state_nxt   = WAIT;
                if (abort_i) begin
                    aborted_nxt = 1'b1;
                    state_nxt   = FINISH;
                end
            end

            WAIT: begin
                timer_en = 1'b1;
                if (cur_done) begin
                    pass_cnt_nxt = pass_cnt + CW'(1);
                    state_nxt    = NEXT;
                end else if (timer_expired) begin
                    mask_nxt[idx] = 1'b1;
                    state_nxt     = NEXT;
                end
                if (abort_i) begin
                    aborted_nxt = 1'b1;
                    state_nxt   = FINISH;
                end
            end

            NEXT: begin
                if (abort_i) begin
                    aborted_nxt = 1'b1;
                    state_nxt   = FINISH;
                end else if (idx == LAST_IDX) begin
                    state_nxt = FINISH;
                end else begin
                    idx_nxt   = idx + IW'(1);
                    state_nxt = LAUNCH;
                end
            end

            FINISH: begin
                state_nxt = IDLE;
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // The outputs are decoded from the registered state. Because of this,
    // an asynchronous reset removes a start strobe or a done pulse at once.
    assign child_start_o  = (state == LAUNCH) ? ({{(N_INST-1){1'b0}}, 1'b1} << idx) : '0;
    assign busy_o         = (state != IDLE);
    assign done_o         = (state == FINISH);
    assign aborted_o      = aborted;
    assign idx_o          = idx;
    assign timeout_mask_o = mask;
    assign pass_count_o   = pass_cnt;

endmodule

// File: tb/tb_child_inst_sequencer.sv
// ---------------------------------------------------------------------------
// tb_child_inst_sequencer
// Directed bench for child_inst_sequencer (N_INST=5, TIMEOUT=16). The bench
// models each child's done response as a per-child delay after its start
// strobe. It compares strobe timing and status against hand-computed values.
// ---------------------------------------------------------------------------
module tb_child_inst_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       go_i;
    logic       abort_i;
    logic [4:0] child_done_i;
    logic [4:0] child_start_o;
    logic       busy_o;
    logic       done_o;
    logic       aborted_o;
    logic [2:0] idx_o;
    logic [4:0] timeout_mask_o;
    logic [2:0] pass_count_o;

    int vectors     = 0;
    int miscompares = 0;

    // Results gathered by one pass of applyStimulus
    int start_cyc[5];
    int start_count;
    int multi_hot;
    int done_cyc;

    child_inst_sequencer #(
        .N_INST  (5),
        .TIMEOUT (16)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .go_i           (go_i),
        .abort_i        (abort_i),
        .child_done_i   (child_done_i),
        .child_start_o  (child_start_o),
        .busy_o         (busy_o),
        .done_o         (done_o),
        .aborted_o      (aborted_o),
        .idx_o          (idx_o),
        .timeout_mask_o (timeout_mask_o),
        .pass_count_o   (pass_count_o)
    );

    always #5 clk = ~clk;

    // Advance to just after the next rising edge. This is where inputs are
    // driven and outputs are sampled.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input int got, input int exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Run one pass. go is sampled at the edge that ends cycle 0, and cycle 1
    // is the first cycle after it. The done of child i rises dly[i] cycles
    // after its start strobe and then stays high. A delay of 0 means the
    // child answers in its first WAIT cycle. An abort, a stray done and a
    // second go can each be injected at one chosen cycle (-1 disables).
    // The task returns with the FSM in FINISH, or after a 200-cycle bound.
    task automatic applyStimulus(input int dly[5], input int abort_at,
                                 input int stray_at, input logic [4:0] stray_mask,
                                 input int go_again_at);
        int         started[5];
        int         cyc;
        logic [4:0] cdone;
        for (int i = 0; i < 5; i++) begin
            started[i]   = -1;
            start_cyc[i] = -1;
        end
        start_count  = 0;
        multi_hot    = 0;
        done_cyc     = -1;
        child_done_i = '0;
        abort_i      = 1'b0;
        go_i         = 1'b1;
        tick();
        go_i = 1'b0;
        cyc  = 1;
        while (cyc < 200 && done_cyc < 0) begin
            if ($countones(child_start_o) > 1) multi_hot++;
            for (int i = 0; i < 5; i++) begin
                if (child_start_o[i]) begin
                    started[i]   = cyc;
                    start_cyc[i] = cyc;
                    start_count++;
                end
            end
            if (done_o) begin
                done_cyc = cyc;
            end else begin
                cdone = '0;
                for (int i = 0; i < 5; i++)
                    if (started[i] >= 0 && (cyc - started[i]) >= dly[i]) cdone[i] = 1'b1;
                if (cyc == stray_at) cdone = cdone | stray_mask;
                child_done_i = cdone;
                abort_i      = (cyc == abort_at);
                go_i         = (cyc == go_again_at);
                tick();
                cyc++;
            end
        end
        child_done_i = '0;
        abort_i      = 1'b0;
        go_i         = 1'b0;
    endtask

    task automatic checkStarts(input string tag, input int e0, input int e1,
                               input int e2, input int e3, input int e4);
        int exp[5];
        exp = '{e0, e1, e2, e3, e4};
        for (int i = 0; i < 5; i++)
            checkOutput($sformatf("%s_start%0d", tag, i), start_cyc[i], exp[i]);
        checkOutput({tag, "_onehot"}, multi_hot, 0);
    endtask

    initial begin
        rst          = 1'b1;
        go_i         = 1'b0;
        abort_i      = 1'b0;
        child_done_i = '0;
        #1;
        checkOutput("rst_busy",  busy_o, 0);
        checkOutput("rst_done",  done_o, 0);
        checkOutput("rst_start", child_start_o, 0);
        checkOutput("rst_idx",   idx_o, 0);
        checkOutput("rst_mask",  timeout_mask_o, 0);
        checkOutput("rst_pass",  pass_count_o, 0);
        checkOutput("rst_abort", aborted_o, 0);
        tick();
        tick();
        rst = 1'b0;
        tick();

        // Test 1: every child answers immediately
        applyStimulus('{0, 0, 0, 0, 0}, -1, -1, 5'b0, -1);
        checkStarts("t1", 1, 4, 7, 10, 13);
        checkOutput("t1_done_cyc", done_cyc, 16);
        checkOutput("t1_busy_fin", busy_o, 1);
        checkOutput("t1_pass",     pass_count_o, 5);
        checkOutput("t1_mask",     timeout_mask_o, 0);
        checkOutput("t1_aborted",  aborted_o, 0);
        checkOutput("t1_idx",      idx_o, 4);
        tick();
        checkOutput("t1_idle_busy", busy_o, 0);
        checkOutput("t1_idle_done", done_o, 0);
        checkOutput("t1_hold_pass", pass_count_o, 5);

        // Test 2: child 2 never answers and times out after 16 WAIT cycles
        applyStimulus('{0, 0, 255, 0, 0}, -1, -1, 5'b0, -1);
        checkStarts("t2", 1, 4, 7, 25, 28);
        checkOutput("t2_done_cyc", done_cyc, 31);
        checkOutput("t2_mask",     timeout_mask_o, 5'b00100);
        checkOutput("t2_pass",     pass_count_o, 4);
        tick();

        // Test 3: child 1 done lands on the final WAIT cycle (timer 15)
        applyStimulus('{0, 16, 0, 0, 0}, -1, -1, 5'b0, -1);
        checkStarts("t3", 1, 4, 22, 25, 28);
        checkOutput("t3_done_cyc", done_cyc, 31);
        checkOutput("t3_mask",     timeout_mask_o, 0);
        checkOutput("t3_pass",     pass_count_o, 5);
        tick();

        // Test 4: abort in the first WAIT cycle of child 3 (cycle 11)
        applyStimulus('{0, 0, 0, 255, 0}, 11, -1, 5'b0, -1);
        checkStarts("t4", 1, 4, 7, 10, -1);
        checkOutput("t4_done_cyc",  done_cyc, 12);
        checkOutput("t4_aborted",   aborted_o, 1);
        checkOutput("t4_pass",      pass_count_o, 3);
        checkOutput("t4_mask",      timeout_mask_o, 0);
        checkOutput("t4_start_cnt", start_count, 4);
        tick();
        // An abort in IDLE must not disturb anything
        abort_i = 1'b1;
        tick();
        abort_i = 1'b0;
        checkOutput("t4_idle_abort_busy", busy_o, 0);
        checkOutput("t4_idle_abort_flag", aborted_o, 1);

        // Test 5: child 1 answers after 5 cycles. Unselected children 2 and
        // 4 pulse done while child 1 is waiting, and go repeats while busy.
        applyStimulus('{0, 5, 0, 0, 0}, -1, 6, 5'b10100, 7);
        checkStarts("t5", 1, 4, 11, 14, 17);
        checkOutput("t5_done_cyc",  done_cyc, 20);
        checkOutput("t5_pass",      pass_count_o, 5);
        checkOutput("t5_mask",      timeout_mask_o, 0);
        checkOutput("t5_start_cnt", start_count, 5);
        checkOutput("t5_aborted",   aborted_o, 0);
        tick();
        checkOutput("t5_no_restart", busy_o, 0);

        // Test 6: reset asserted in the middle of child 1's WAIT
        go_i = 1'b1;
        tick();
        go_i         = 1'b0;
        child_done_i = 5'b00001;
        tick();
        tick();
        tick();
        child_done_i = '0;
        checkOutput("t6_pre_start", child_start_o, 5'b00010);
        tick();
        checkOutput("t6_pre_pass", pass_count_o, 1);
        checkOutput("t6_pre_idx",  idx_o, 1);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("t6_rst_busy",  busy_o, 0);
        checkOutput("t6_rst_idx",   idx_o, 0);
        checkOutput("t6_rst_pass",  pass_count_o, 0);
        checkOutput("t6_rst_start", child_start_o, 0);
        checkOutput("t6_rst_done",  done_o, 0);
        tick();
        rst = 1'b0;
        tick();
        applyStimulus('{0, 0, 0, 0, 0}, -1, -1, 5'b0, -1);
        checkStarts("t6", 1, 4, 7, 10, 13);
        checkOutput("t6_done_cyc", done_cyc, 16);
        checkOutput("t6_pass",     pass_count_o, 5);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
